// File: rtl/fir_stream_controller.sv
//------------------------------------------------------------------------------
// Module   : fir_stream_controller
// Purpose  : Sequences a FIR tap chain from a valid/ready sample stream.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fir_stream_controller #(
    parameter int N      = 32,
    parameter int TAPS   = 8,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [N-1:0]     m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [N-1:0]     chain_x,
    output logic             chain_ena,
    input  logic [N-1:0]     chain_y,
    input  logic             flush,
    output logic             busy,
    output logic [CNT_W-1:0] sample_count
);

    // One counter serves both the settle wait and the flush length.
    localparam int C_CMAX = (TAPS > SETTLE) ? TAPS : SETTLE;
    localparam int C_CW   = (C_CMAX > 1) ? $clog2(C_CMAX) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [C_CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]      chain_x_q, chain_x_d;
    logic [N-1:0]      m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              w_capture;

    assign w_capture = (state_q == ST_SETTLE) && (cnt_q == '0) && (!m_valid_q || m_ready);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        chain_x_d = chain_x_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
        count_d   = count_q;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d   = ST_FLUSH;
                    cnt_d     = C_CW'(TAPS - 1);
                    chain_x_d = '0;
                end else if (s_valid) begin
                    state_d   = ST_SETTLE;
                    cnt_d     = C_CW'(SETTLE - 1);
                    chain_x_d = s_data;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - C_CW'(1);
                end else if (w_capture) begin
                    m_data_d  = chain_y;
                    m_valid_d = 1'b1;
                    count_d   = count_q + CNT_W'(1);
                    state_d   = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - C_CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            chain_x_q <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            chain_x_q <= chain_x_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            count_q   <= count_d;
        end
    end

    // Strobe is suppressed while reset is held so an aborted capture never shifts.
    assign chain_ena    = rst && (w_capture || (state_q == ST_FLUSH));
    assign s_ready      = (state_q == ST_IDLE) && !flush;
    assign busy         = (state_q != ST_IDLE);
    assign chain_x      = chain_x_q;
    assign m_data       = m_data_q;
    assign m_valid      = m_valid_q;
    assign sample_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_stream_controller.sv
//------------------------------------------------------------------------------
// Module   : tb_fir_stream_controller
// Purpose  : Self-checking bench with a 4-tap chain model and result scoreboard.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fir_stream_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] chain_x;
    logic        chain_ena;
    logic [31:0] chain_y;
    logic        flush = 1'b0;
    logic        busy;
    logic [15:0] sample_count;

    logic        s_ready4, m_valid4, chain_ena4, busy4;
    logic [31:0] m_data4, chain_x4, chain_y4;
    logic [3:0]  sample_count4;

    int tests = 0;
    int fails = 0;
    int ena_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] hist [3] = '{32'd0, 32'd0, 32'd0};
    logic [31:0] tap_d [3] = '{32'd0, 32'd0, 32'd0};
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    fir_stream_controller #(.N(32), .TAPS(4), .SETTLE(2), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .chain_x(chain_x), .chain_ena(chain_ena), .chain_y(chain_y),
        .flush(flush), .busy(busy), .sample_count(sample_count)
    );

    // Same stimulus, narrow counter; runs in lockstep with u_dut.
    fir_stream_controller #(.N(32), .TAPS(4), .SETTLE(2), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready4),
        .m_data(m_data4), .m_valid(m_valid4), .m_ready(m_ready),
        .chain_x(chain_x4), .chain_ena(chain_ena4), .chain_y(chain_y4),
        .flush(flush), .busy(busy4), .sample_count(sample_count4)
    );
    assign chain_y4 = chain_x4;

    // Tap chain, b = {1,2,3,4}; not reset, like the real taps.
    assign chain_y = chain_x + 32'd2 * tap_d[0] + 32'd3 * tap_d[1] + 32'd4 * tap_d[2];
    always @(posedge clk) begin
        if (chain_ena) begin
            tap_d[0] <= chain_x;
            tap_d[1] <= tap_d[0];
            tap_d[2] <= tap_d[1];
        end
    end

    always @(negedge clk) begin
        if (chain_ena) ena_cnt++;
        if (rst && m_valid && m_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_output: got m_data=%0d, none expected", m_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (m_data !== mon_exp) begin
                    fails++;
                    $display("FAIL result_data: got %0d, expected %0d", m_data, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        bit ok = 1'b0;
        s_data  = d;
        s_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (s_ready) begin
                exp_q.push_back(d + 32'd2 * hist[0] + 32'd3 * hist[1] + 32'd4 * hist[2]);
                hist[2] = hist[1];
                hist[1] = hist[0];
                hist[0] = d;
                ok = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL send_timeout: sample %0d not accepted, expected acceptance", d);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        tests++;
        if (got !== expv) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        if (chain_ena !== 1'b0) begin fails++; $display("FAIL rst_ena: got %b, expected 0", chain_ena); end
        tests++;
        if (m_valid !== 1'b0 || m_data !== 32'd0 || sample_count !== 16'd0 || busy !== 1'b0 || chain_x !== 32'd0) begin
            fails++;
            $display("FAIL rst_state: got v=%b d=%0d cnt=%0d busy=%b x=%0d, expected all 0",
                     m_valid, m_data, sample_count, busy, chain_x);
        end
        tests++;
        rst = 1'b1;
        #1;
        if (s_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b, expected 1", s_ready); end
        tests++;
    endtask

    task automatic test_impulse();
        int ena0 = ena_cnt;
        logic [31:0] samples [5] = '{32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(samples[i]);
            chk("latency_e0", {31'd0, m_valid}, 32'd0);
            tick();
            chk("latency_e1", {31'd0, m_valid}, 32'd0);
            tick();
            chk("latency_e2", {31'd0, m_valid}, 32'd1);
        end
        chk("impulse_ena_pulses", ena_cnt - ena0, 32'd5);
        chk("impulse_count", {16'd0, sample_count}, 32'd5);
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b1;
        send(32'd1);
        m_ready = 1'b0;
        tick();
        tick();
        chk("bp_first_data", m_data, 32'd1);
        send(32'd0);
        repeat (3) tick();
        chk("bp_stall_busy", {31'd0, busy}, 32'd1);
        chk("bp_stall_ena", {31'd0, chain_ena}, 32'd0);
        chk("bp_stall_ready", {31'd0, s_ready}, 32'd0);
        chk("bp_stall_data", m_data, 32'd1);
        chk("bp_stall_x", chain_x, 32'd0);
        m_ready = 1'b1;
        #1;
        chk("bp_release_ena", {31'd0, chain_ena}, 32'd1);
        tick();
        chk("bp_release_valid", {31'd0, m_valid}, 32'd1);
        chk("bp_release_data", m_data, 32'd2);
        tick();
        chk("bp_drained", {31'd0, m_valid}, 32'd0);
    endtask

    task automatic test_flush();
        logic [15:0] cnt0;
        send(32'd5); tick(); tick();
        send(32'd6); tick(); tick();
        send(32'd7); tick(); tick();
        cnt0 = sample_count;
        flush = 1'b1;
        s_valid = 1'b1;
        s_data = 32'd9;
        #1;
        chk("flush_ready_low", {31'd0, s_ready}, 32'd0);
        tick();
        flush = 1'b0;
        s_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("flush_busy", {31'd0, busy}, 32'd1);
            chk("flush_x", chain_x, 32'd0);
            chk("flush_ena", {31'd0, chain_ena}, 32'd1);
            tick();
        end
        chk("flush_done", {31'd0, busy}, 32'd0);
        chk("flush_count", {16'd0, sample_count}, {16'd0, cnt0});
        hist = '{32'd0, 32'd0, 32'd0};
        send(32'd1); tick(); tick();
        chk("flush_clear_data", m_data, 32'd1);
    endtask

    task automatic test_reset_abort();
        logic [31:0] saved [3];
        int ena0;
        saved = hist;
        send(32'd3);
        tick();
        ena0 = ena_cnt;
        rst = 1'b0;
        #1;
        chk("abort_ena", {31'd0, chain_ena}, 32'd0);
        tick();
        chk("abort_valid", {31'd0, m_valid}, 32'd0);
        chk("abort_data", m_data, 32'd0);
        chk("abort_count", {16'd0, sample_count}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_no_pulse", ena_cnt - ena0, 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_ready", {31'd0, s_ready}, 32'd1);
        void'(exp_q.pop_back());
        hist = saved;
        tick();
    endtask

    task automatic test_count_wrap();
        for (int i = 1; i <= 17; i++) begin
            send(32'(i));
            tick();
            tick();
            if (i == 16) begin
                chk("wrap_at_16", {28'd0, sample_count4}, 32'd0);
                chk("count_16", {16'd0, sample_count}, 32'd16);
            end
        end
        chk("wrap_end", {28'd0, sample_count4}, 32'd1);
    endtask

    task automatic test_flush_in_settle();
        logic [15:0] cnt0 = sample_count;
        send(32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("sflush_valid", {31'd0, m_valid}, 32'd1);
        chk("sflush_idle", {31'd0, busy}, 32'd0);
        chk("sflush_count", {16'd0, sample_count}, {16'd0, cnt0 + 16'd1});
        tick();
        chk("sflush_no_flush", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_back_to_back();
        test_flush();
        test_reset_abort();
        test_count_wrap();
        test_flush_in_settle();
        repeat (4) tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fir_stream_controller.md
Name: fir_stream_controller

Overview:
- Drives a chain of FIR tapped-delay taps from a valid/ready sample stream and returns the filtered result on a second valid/ready stream.
- Presents each sample on the first tap's x input and waits SETTLE cycles for the combinational multiply-add chain to resolve.
- Then captures the chain's y output and pulses the chain enable once, shifting the delay line.
- Also provides a flush command that clears the delay line with zeros.
- Sits between the sample source and sink and the tap chain; the taps' clk and clk_d are both tied to clk.

Parameters:
- N, 32: sample/result width; matches the tap width.
- TAPS, 8: number of taps in the chain; sets the flush length.
- SETTLE, 2: cycles allowed for chain settling. Legal values are 1 or more.
- CNT_W, 16: width of the output sample counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- s_data  in  N  input sample
- s_valid  in  1  input sample valid
- s_ready  out  1  controller accepts a sample
- m_data  out  N  filtered result
- m_valid  out  1  result valid
- m_ready  in  1  sink accepts the result
- chain_x  out  N  to x_in of the first tap
- chain_ena  out  1  to ena of every tap; one-cycle shift strobe
- chain_y  in  N  from y_out of the last tap, whose y_in is tied to 0
- flush  in  1  request to zero the delay line
- busy  out  1  high when state is not IDLE
- sample_count  out  CNT_W  number of results captured; wraps

Behaviour:
- Reset (rst low at a posedge):
  - State becomes IDLE.
  - chain_x=0, m_data=0, m_valid=0, sample_count=0, counters=0.
  - chain_ena=0 throughout any cycle with rst low.
  - Reset mid-operation aborts SETTLE/FLUSH with no shift pulse. The tap contents are not cleared by this block.
- States: IDLE, SETTLE, FLUSH.
- s_ready is combinational: (state==IDLE) and !flush.
- IDLE:
  - flush=1 takes priority: go to FLUSH, flush counter = TAPS-1, chain_x <= 0.
  - Otherwise s_valid & s_ready: chain_x <= s_data, settle counter = SETTLE-1, go to SETTLE.
- SETTLE:
  - Counter decrements each cycle while it is nonzero.
  - When counter==0 and (!m_valid or m_ready), this is the capture cycle:
    - chain_ena=1 for exactly this cycle.
    - At the edge: m_data <= chain_y, m_valid <= 1, sample_count += 1 (mod 2^CNT_W), state goes to IDLE.
  - If counter==0 and m_valid & !m_ready: hold with chain_ena=0 and chain_x stable until the sink drains.
- FLUSH:
  - chain_x=0 and chain_ena=1 every cycle, for exactly TAPS consecutive cycles, then IDLE.
  - No results are produced, and sample_count is unchanged.
  - A pending m_valid/m_data is unaffected and can still be consumed.
- flush asserted outside IDLE is ignored; it is not queued.
- m_valid:
  - Cleared on an edge with m_ready=1 when no capture occurs on that edge.
  - A capture on the same edge as m_ready keeps m_valid=1 with the new data.
  - m_data is stable while m_valid & !m_ready.
- chain_ena is decoded from registered state and counters plus m_valid/m_ready. It never asserts in IDLE.
- Latency with no backpressure:
  - Sample accepted at edge E0; chain_ena high in the cycle before edge E0+SETTLE.
  - m_valid rises at E0+SETTLE; s_ready returns at the same edge.
  - Maximum throughput is one sample per SETTLE+1 cycles.
- Widths: no arithmetic on data. chain_y is passed through unmodified; truncation is the chain's responsibility.

Test Plan:
1. Bench chain model: TAPS=4, b={1,2,3,4}, N=32, SETTLE=2, m_ready=1. Send samples 1,0,0,0,0 back-to-back.
   -> m_data = 1,2,3,4,0. Each m_valid rises 2 edges after its acceptance. Exactly one chain_ena pulse per sample. sample_count=5.
2. Hold m_ready=0 after the first result, then send the second sample.
   -> Controller stalls in SETTLE with chain_ena=0, s_ready=0, and m_data=1 held.
   -> When m_ready is raised, the capture cycle and m_ready coincide, so m_valid stays 1 with m_data=2.
3. After loading samples 5,6,7, assert flush for one IDLE cycle with s_valid=1.
   -> s_ready=0 in that cycle; busy for exactly 4 cycles with chain_x=0 and chain_ena=1.
   -> Next sample 1 yields m_data=1, proving the delay line is clear. sample_count is unchanged by the flush.
4. Pull rst low during the second SETTLE cycle.
   -> No chain_ena pulse; the next cycle shows state IDLE with m_valid=0, m_data=0, sample_count=0 and s_ready=1 once rst is high.
5. With CNT_W=4, stream 17 samples.
   -> sample_count wraps to 0 after 16 and reads 1 at the end.
6. Assert flush while in SETTLE.
   -> Ignored: the capture proceeds normally and no FLUSH follows unless flush is still high in IDLE.
